am_tick_timer: RTL and testbench

Reloadable interval timer that sits directly downstream of an am25ls163 prescaler chain. It consumes the prescaler's carry output `co` as a one-cycle tick enable, counts ticks down from a programmable period, and raises a sticky interrupt with acknowledge handshake on expiry. It supports one-shot and periodic modes, and flags expiries that arrive before the previous one was acknowledged.

---
 rtl/am_tick_timer_pkg.sv | 12 +
 rtl/am_tick_timer_if.sv | 25 ++
 rtl/am_tick_dncnt.sv | 24 ++
 rtl/am_tick_timer.sv | 114 +++++++++++
 tb/tb_am_tick_timer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/am_tick_timer_pkg.sv
// rtl/am_tick_timer_pkg.sv - shared state and mode constants for the tick timer
package am_tick_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/am_tick_timer_if.sv
// rtl/am_tick_timer_if.sv - host control/status bundle of the tick timer
interface am_tick_timer_if #(parameter int WIDTH = 8);

   logic [WIDTH-1:0] din;
   logic             wr_period_;
   logic             start_;
   logic             stop_;
   logic             mode;
   logic             ack_;
   logic [WIDTH-1:0] q;
   logic             irq;
   logic             ovr;
   logic             busy;

   modport master (
      output din, wr_period_, start_, stop_, mode, ack_,
      input  q, irq, ovr, busy
   );

   modport slave (
      input  din, wr_period_, start_, stop_, mode, ack_,
      output q, irq, ovr, busy
   );

endinterface

// File: rtl/am_tick_dncnt.sv
// rtl/am_tick_dncnt.sv - loadable down-counter with a q==1 flag
module am_tick_dncnt #(
   parameter int WIDTH = 8
) (
   input  logic             cp,
   input  logic             ld,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             one
);

   // Load wins over enable; the parent clears the count by loading zero.
   always_ff @(posedge cp) begin
      if (ld) begin
         q <= d;
      end else if (en) begin
         q <= q - WIDTH'(1);
      end
   end

   assign one = (q == WIDTH'(1));

endmodule

// File: rtl/am_tick_timer.sv
// rtl/am_tick_timer.sv - reloadable interval timer driven by a prescaler carry tick
module am_tick_timer
   import am_tick_timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          cp,
   input  logic          clr_,
   input  logic          tick,
   am_tick_timer_if.slave bus
);

   state_t           state, state_n;
   logic [WIDTH-1:0] per, per_n;
   logic             mode_lat, mode_n;
   logic             irq, irq_n;
   logic             ovr, ovr_n;
   logic             expire;
   logic             cnt_ld;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;
   logic             cnt_one;

   am_tick_dncnt #(.WIDTH(WIDTH)) u_cnt (
      .cp  (cp),
      .ld  (cnt_ld),
      .en  (cnt_en),
      .d   (cnt_d),
      .q   (cnt_q),
      .one (cnt_one)
   );

   always_comb begin
      state_n = state;
      per_n   = per;
      mode_n  = mode_lat;
      irq_n   = irq;
      ovr_n   = ovr;
      expire  = 1'b0;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      cnt_d   = per;

      // A period write only lands in per; start and reload read the old value.
      if (!bus.wr_period_) begin
         per_n = bus.din;
      end

      if (!clr_) begin
         cnt_ld = 1'b1;
         cnt_d  = '0;
      end else begin
         if (!bus.stop_) begin
            state_n = ST_IDLE;
            cnt_ld  = 1'b1;
            cnt_d   = '0;
         end else if (!bus.start_) begin
            cnt_ld = 1'b1;
            cnt_d  = per;
            if (per == '0) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_RUN;
               mode_n  = bus.mode;
            end
         end else if (state == ST_RUN && tick) begin
            if (cnt_one) begin
               expire = 1'b1;
               cnt_ld = 1'b1;
               if (mode_lat == MODE_PERIODIC && per != '0) begin
                  cnt_d = per;
               end else begin
                  cnt_d   = '0;
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end

         // An ack on the expiry edge retires the old interrupt, not the new one.
         if (expire) begin
            irq_n = 1'b1;
            ovr_n = bus.ack_ ? (ovr | irq) : 1'b0;
         end else if (!bus.ack_) begin
            irq_n = 1'b0;
            ovr_n = 1'b0;
         end
      end
   end

   always_ff @(posedge cp) begin
      if (!clr_) begin
         state    <= ST_IDLE;
         per      <= '0;
         mode_lat <= MODE_ONESHOT;
         irq      <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         state    <= state_n;
         per      <= per_n;
         mode_lat <= mode_n;
         irq      <= irq_n;
         ovr      <= ovr_n;
      end
   end

   assign bus.q    = cnt_q;
   assign bus.irq  = irq;
   assign bus.ovr  = ovr;
   assign bus.busy = (state == ST_RUN);

endmodule

// File: tb/tb_am_tick_timer.sv
// tb/tb_am_tick_timer.sv - self-checking bench for am_tick_timer
module tb_am_tick_timer;

   logic cp;
   logic clr_;
   logic tick;

   am_tick_timer_if #(.WIDTH(8)) bus ();

   am_tick_timer #(.WIDTH(8)) dut (
      .cp   (cp),
      .clr_ (clr_),
      .tick (tick),
      .bus  (bus)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   typedef struct {
      logic       clr;
      logic       wr;
      logic [7:0] din;
      logic       start;
      logic       stop;
      logic       mode;
      logic       tk;
      logic       ack;
      logic [7:0] q;
      logic       irq;
      logic       ovr;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state kept as plain integers.
   int m_q, m_per, m_mode, m_irq, m_ovr, m_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic w, input logic [7:0] d, input logic s,
                        input logic p, input logic m, input logic t, input logic a);
      clr_           = c;
      bus.wr_period_ = w;
      bus.din        = d;
      bus.start_     = s;
      bus.stop_      = p;
      bus.mode       = m;
      tick           = t;
      bus.ack_       = a;
   endtask

   task automatic idle_in();
      drive(1, 1, 8'd0, 1, 1, 0, 0, 1);
   endtask

   task automatic model_edge();
      int  old_per;
      bit  ex;
      old_per = m_per;
      ex      = 0;
      if (!clr_) begin
         m_q = 0; m_per = 0; m_mode = 0; m_irq = 0; m_ovr = 0; m_busy = 0;
         return;
      end
      if (!bus.wr_period_) m_per = int'(bus.din);
      if (!bus.stop_) begin
         m_busy = 0;
         m_q    = 0;
      end else if (!bus.start_) begin
         m_q = old_per;
         if (old_per == 0) begin
            m_busy = 0;
         end else begin
            m_busy = 1;
            m_mode = int'(bus.mode);
         end
      end else if (m_busy == 1 && tick) begin
         if (m_q > 1) begin
            m_q = m_q - 1;
         end else begin
            ex = 1;
            if (m_mode == 1 && old_per != 0) begin
               m_q = old_per;
            end else begin
               m_q    = 0;
               m_busy = 0;
            end
         end
      end
      if (ex) begin
         if (!bus.ack_) m_ovr = 0;
         else if (m_irq == 1) m_ovr = 1;
         m_irq = 1;
      end else if (!bus.ack_) begin
         m_irq = 0;
         m_ovr = 0;
      end
   endtask

   task automatic cycle();
      @(posedge cp);
      model_edge();
      @(negedge cp);
   endtask

   task automatic chk_all(input string tag, input int q, input int irq, input int ovr, input int busy);
      chk({tag, ".q"},    32'(bus.q),    32'(q));
      chk({tag, ".irq"},  32'(bus.irq),  32'(irq));
      chk({tag, ".ovr"},  32'(bus.ovr),  32'(ovr));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
   endtask

   task automatic do_reset();
      drive(0, 1, 8'd0, 1, 1, 0, 0, 1);
      cycle();
      idle_in();
   endtask

   initial begin
      int irq_cyc[$];
      idle_in();
      m_q = 0; m_per = 0; m_mode = 0; m_irq = 0; m_ovr = 0; m_busy = 0;
      @(negedge cp);

      // clr wr din start stop mode tick ack | q irq ovr busy
      vecs.push_back('{0, 1, 8'd0, 1, 1, 0, 0, 1, 8'd0, 0, 0, 0});
      vecs.push_back('{1, 0, 8'd5, 1, 1, 0, 0, 1, 8'd0, 0, 0, 0});
      vecs.push_back('{1, 1, 8'd0, 0, 1, 0, 1, 1, 8'd5, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd4, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd3, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd2, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd1, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd0, 1, 0, 0});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd0, 1, 0, 0});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 0, 8'd0, 0, 0, 0});
      vecs.push_back('{1, 1, 8'd0, 0, 1, 0, 0, 1, 8'd5, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd4, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 0, 0, 0, 1, 1, 8'd0, 0, 0, 0});
      vecs.push_back('{1, 0, 8'd7, 1, 1, 0, 0, 1, 8'd0, 0, 0, 0});
      vecs.push_back('{1, 1, 8'd0, 0, 1, 0, 0, 1, 8'd7, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd6, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd5, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd4, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd3, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 1, 0, 1, 1, 8'd2, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 0, 1, 0, 1, 1, 8'd7, 0, 0, 1});
      vecs.push_back('{1, 1, 8'd0, 1, 0, 0, 1, 1, 8'd0, 0, 0, 0});

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].wr, vecs[i].din, vecs[i].start,
               vecs[i].stop, vecs[i].mode, vecs[i].tk, vecs[i].ack);
         cycle();
         chk_all($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].irq),
                 int'(vecs[i].ovr), int'(vecs[i].busy));
      end

      // Periodic, period 3, tick every other cycle, ack after each irq.
      do_reset();
      drive(1, 0, 8'd3, 1, 1, 1, 0, 1);
      cycle();
      drive(1, 1, 8'd0, 0, 1, 1, 0, 1);
      cycle();
      for (int c = 1; c <= 24; c++) begin
         drive(1, 1, 8'd0, 1, 1, 1, logic'(c % 2), bus.irq ? 1'b0 : 1'b1);
         cycle();
         if (bus.irq) begin
            irq_cyc.push_back(c);
            chk($sformatf("per3.reload_q@%0d", c), 32'(bus.q), 32'd3);
         end
         if (bus.ovr) chk($sformatf("per3.ovr@%0d", c), 32'(bus.ovr), 32'd0);
      end
      chk("per3.irq_count", 32'(irq_cyc.size()), 32'd4);
      for (int k = 1; k < irq_cyc.size(); k++)
         chk($sformatf("per3.spacing%0d", k), 32'(irq_cyc[k] - irq_cyc[k-1]), 32'd6);

      // Periodic, period 2, no ack: overrun, then ack, then ack on expiry.
      do_reset();
      drive(1, 0, 8'd2, 1, 1, 1, 0, 1);
      cycle();
      drive(1, 1, 8'd0, 0, 1, 1, 0, 1);
      cycle();
      drive(1, 1, 8'd0, 1, 1, 1, 1, 1);
      cycle();
      cycle();
      chk_all("ovr.first", 2, 1, 0, 1);
      cycle();
      cycle();
      chk_all("ovr.second", 2, 1, 1, 1);
      drive(1, 1, 8'd0, 1, 1, 1, 0, 0);
      cycle();
      chk_all("ovr.ack", 2, 0, 0, 1);
      drive(1, 1, 8'd0, 1, 1, 1, 1, 1);
      cycle();
      cycle();
      chk_all("ovr.third", 2, 1, 0, 1);
      cycle();
      drive(1, 1, 8'd0, 1, 1, 1, 1, 0);
      cycle();
      chk_all("ovr.ack_on_expiry", 2, 1, 0, 1);

      // Zero period start, then period write during RUN, then reset on expiry.
      do_reset();
      drive(1, 1, 8'd0, 0, 1, 1, 0, 1);
      cycle();
      chk_all("per0.start", 0, 0, 0, 0);
      drive(1, 0, 8'd2, 1, 1, 1, 0, 1);
      cycle();
      drive(1, 1, 8'd0, 0, 1, 1, 1, 1);
      cycle();
      chk_all("wrrun.start", 2, 0, 0, 1);
      drive(1, 0, 8'd4, 1, 1, 1, 1, 1);
      cycle();
      chk_all("wrrun.write", 1, 0, 0, 1);
      drive(1, 1, 8'd0, 1, 1, 1, 1, 1);
      cycle();
      chk_all("wrrun.reload", 4, 1, 0, 1);
      drive(1, 1, 8'd0, 1, 1, 1, 1, 0);
      cycle();
      drive(1, 1, 8'd0, 1, 1, 1, 1, 1);
      cycle();
      cycle();
      chk_all("clr.pre", 1, 0, 0, 1);
      drive(0, 1, 8'd0, 1, 1, 1, 1, 1);
      cycle();
      chk_all("clr.on_expiry", 0, 0, 0, 0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 49) != 0,
               $urandom_range(0, 7) != 0,
               ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
               $urandom_range(0, 9) != 0,
               $urandom_range(0, 24) != 0,
               logic'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0);
         cycle();
         chk_all($sformatf("rnd%0d", n), m_q, m_irq, m_ovr, m_busy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
